inst_mem: RTL and testbench

Instruction memory for the CPU. It is the responder side of the fetch unit's memory interface. It serves one 16-bit word per cycle, with one cycle of read latency, against the 13-bit word address the fetch unit drives. It also contains a byte-stream program loader that packs incoming bytes into little-endian words. The loader writes into memory through per-lane byte enables, so no read-modify-write is needed.

---
 rtl/inst_mem.sv | 152 +++++++++++++++
 tb/tb_inst_mem.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem.sv
// Instruction memory: 1-cycle read port for the fetch unit plus a byte-stream
// program loader that packs bytes into little-endian 16-bit words and writes
// them through per-lane byte enables.
module inst_mem #(
    parameter int DEPTH_WORDS = 8192
) (
    input  logic        clk,
    input  logic        rst_async,
    input  logic [12:0] mem_inst_addr,
    output logic [15:0] mem_instr,
    input  logic        load_start,
    input  logic [13:0] load_base,
    input  logic [7:0]  load_byte,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic        load_done,
    output logic        loading,
    output logic [14:0] load_count,
    output logic        load_wrap
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOADING = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    localparam logic [13:0] PTR_LAST  = 14'h3FFF;
    localparam logic [14:0] COUNT_MAX = 15'h7FFF;

    // Byte-lane storage: lo holds even byte addresses, hi holds odd ones.
    logic [7:0] lo_mem [DEPTH_WORDS];
    logic [7:0] hi_mem [DEPTH_WORDS];

    state_t      state_q;
    logic [13:0] ptr_q, ptr_d;
    logic        pending_q;
    logic [7:0]  pack_lo_q;
    logic [14:0] count_q, count_d;
    logic        wrap_q;
    logic        ready_q;
    logic        loading_q;
    logic [15:0] instr_q;

    logic        accept;
    logic        hi_we;
    logic        lo_we;
    logic [12:0] wr_word;

    // Write enables derive from registered state, so an async reset that
    // returns the FSM to IDLE also cancels any pending flush.
    assign accept  = (state_q == S_LOADING) && load_valid;
    assign hi_we   = accept && ptr_q[0];
    assign lo_we   = pending_q && ((accept && ptr_q[0]) || (state_q == S_DRAIN));
    assign wr_word = ptr_q[13:1];

    // Next pointer (14-bit wrap) and saturating byte count.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        ptr_d   = ptr_q + 14'd1;
        count_d = count_q;
        if (count_q != COUNT_MAX) begin
            count_d = count_q + 15'd1;
        end
    end

    // Read port: registered, read-first against a same-edge write.
    always_ff @(posedge clk or posedge rst_async) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
        if (rst_async) begin
            instr_q <= 16'h0000;
        end else begin
            instr_q <= {hi_mem[mem_inst_addr], lo_mem[mem_inst_addr]};
        end
    end

    // Byte-lane array writes; each lane is written only when its byte is loaded.
    always_ff @(posedge clk) begin
        // NOTE: the arrays are deliberately outside reset; contents survive rst_async and map to plain RAM.
        if (hi_we) begin
            hi_mem[wr_word] <= load_byte;
        end
        if (lo_we) begin
            lo_mem[wr_word] <= pack_lo_q;
        end
    end

    // Loader FSM with registered handshake/status outputs.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state_q   <= S_IDLE;
            ptr_q     <= 14'd0;
            pending_q <= 1'b0;
            pack_lo_q <= 8'd0;
            count_q   <= 15'd0;
            wrap_q    <= 1'b0;
            ready_q   <= 1'b0;
            loading_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_start) begin
                        ptr_q     <= load_base;
                        count_q   <= 15'd0;
                        wrap_q    <= 1'b0;
                        pending_q <= 1'b0;
                        ready_q   <= 1'b1;
                        loading_q <= 1'b1;
                        state_q   <= S_LOADING;
                    end
                end
                S_LOADING: begin
                    if (load_valid) begin
                        if (!ptr_q[0]) begin
                            pack_lo_q <= load_byte;
                            pending_q <= 1'b1;
                        end else begin
                            pending_q <= 1'b0;
                        end
                        ptr_q   <= ptr_d;
                        count_q <= count_d;
                        if (ptr_q == PTR_LAST) begin
                            wrap_q <= 1'b1;
                        end
                    end
                    if (load_done) begin
                        ready_q <= 1'b0;
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    pending_q <= 1'b0;
                    loading_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    pending_q <= 1'b0;
                    ready_q   <= 1'b0;
                    loading_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_instr  = instr_q;
    assign load_ready = ready_q;
    assign loading    = loading_q;
    assign load_count = count_q;
    assign load_wrap  = wrap_q;

endmodule

// File: tb/tb_inst_mem.sv
// Directed bench for inst_mem: loader packing, flush, read-first, wrap, reset.
module tb_inst_mem;

    logic        clk;
    logic        rst_async;
    logic [12:0] mem_inst_addr;
    logic [15:0] mem_instr;
    logic        load_start;
    logic [13:0] load_base;
    logic [7:0]  load_byte;
    logic        load_valid;
    logic        load_ready;
    logic        load_done;
    logic        loading;
    logic [14:0] load_count;
    logic        load_wrap;

    int n_cmp = 0;
    int n_bad = 0;

    inst_mem #(.DEPTH_WORDS(8192)) dut (
        .clk           (clk),
        .rst_async     (rst_async),
        .mem_inst_addr (mem_inst_addr),
        .mem_instr     (mem_instr),
        .load_start    (load_start),
        .load_base     (load_base),
        .load_byte     (load_byte),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_done     (load_done),
        .loading       (loading),
        .load_count    (load_count),
        .load_wrap     (load_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; inputs are driven and outputs sampled 1ns after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [13:0] base);
        load_start = 1'b1;
        load_base  = base;
        cyc();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        load_valid = 1'b1;
        load_byte  = b;
        cyc();
        load_valid = 1'b0;
    endtask

    task automatic do_done();
        load_done = 1'b1;
        cyc();
        load_done = 1'b0;
        cyc();
    endtask

    task automatic read_word(input logic [12:0] addr, output logic [15:0] data);
        mem_inst_addr = addr;
        cyc();
        data = mem_instr;
    endtask

    task automatic test_reset();
        rst_async = 1'b1;
        cyc();
        cyc();
        n_cmp++;
        if (mem_instr !== 16'h0000) begin n_bad++; $display("FAIL reset_instr: got %h want 0000", mem_instr); end
        n_cmp++;
        if ({load_ready, loading, load_wrap} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {load_ready, loading, load_wrap}); end
        n_cmp++;
        if (load_count !== 15'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", load_count); end
        rst_async = 1'b0;
        cyc();
    endtask

    task automatic test_aligned();
        logic [15:0] d;
        do_start(14'd0);
        n_cmp++;
        if ({loading, load_ready} !== 2'b11) begin n_bad++; $display("FAIL start_flags: got %b want 11", {loading, load_ready}); end
        send_byte(8'h11);
        send_byte(8'h22);
        // load_start mid-session must be ignored
        do_start(14'd8);
        n_cmp++;
        if (load_count !== 15'd2) begin n_bad++; $display("FAIL ignore_start_count: got %0d want 2", load_count); end
        send_byte(8'h33);
        send_byte(8'h44);
        n_cmp++;
        if (load_count !== 15'd4) begin n_bad++; $display("FAIL aligned_count: got %0d want 4", load_count); end
        load_done = 1'b1;
        cyc();
        load_done = 1'b0;
        n_cmp++;
        if ({loading, load_ready} !== 2'b10) begin n_bad++; $display("FAIL drain_flags: got %b want 10", {loading, load_ready}); end
        cyc();
        n_cmp++;
        if (loading !== 1'b0) begin n_bad++; $display("FAIL idle_loading: got %b want 0", loading); end
        read_word(13'd0, d);
        n_cmp++;
        if (d !== 16'h2211) begin n_bad++; $display("FAIL aligned_w0: got %h want 2211", d); end
        read_word(13'd1, d);
        n_cmp++;
        if (d !== 16'h4433) begin n_bad++; $display("FAIL aligned_w1: got %h want 4433", d); end
    endtask

    task automatic test_odd_base();
        logic [15:0] d;
        do_start(14'd4);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'hFF);
        do_done();
        do_start(14'd5);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        do_done();
        read_word(13'd2, d);
        n_cmp++;
        if (d !== 16'hAAFF) begin n_bad++; $display("FAIL odd_w2: got %h want AAFF", d); end
        read_word(13'd3, d);
        n_cmp++;
        if (d !== 16'hCCBB) begin n_bad++; $display("FAIL odd_w3: got %h want CCBB", d); end
        read_word(13'd1, d);
        n_cmp++;
        if (d !== 16'h4433) begin n_bad++; $display("FAIL odd_w1_untouched: got %h want 4433", d); end
    endtask

    task automatic test_flush();
        do_start(14'd0);
        send_byte(8'hFF);
        send_byte(8'hFF);
        do_done();
        do_start(14'd0);
        mem_inst_addr = 13'd0;
        load_valid    = 1'b1;
        load_byte     = 8'h77;
        load_done     = 1'b1;
        cyc();
        load_valid = 1'b0;
        load_done  = 1'b0;
        n_cmp++;
        if ({loading, load_ready} !== 2'b10) begin n_bad++; $display("FAIL flush_drain_flags: got %b want 10", {loading, load_ready}); end
        n_cmp++;
        if (load_count !== 15'd1) begin n_bad++; $display("FAIL flush_count: got %0d want 1", load_count); end
        cyc();
        n_cmp++;
        if (mem_instr !== 16'hFFFF) begin n_bad++; $display("FAIL flush_before: got %h want FFFF", mem_instr); end
        n_cmp++;
        if (loading !== 1'b0) begin n_bad++; $display("FAIL flush_loading_fall: got %b want 0", loading); end
        cyc();
        n_cmp++;
        if (mem_instr !== 16'hFF77) begin n_bad++; $display("FAIL flush_after: got %h want FF77", mem_instr); end
    endtask

    task automatic test_read_during_write();
        do_start(14'd0);
        send_byte(8'h11);
        send_byte(8'h22);
        do_done();
        do_start(14'd0);
        send_byte(8'h55);
        mem_inst_addr = 13'd0;
        load_valid    = 1'b1;
        load_byte     = 8'h66;
        cyc();
        load_valid = 1'b0;
        n_cmp++;
        if (mem_instr !== 16'h2211) begin n_bad++; $display("FAIL rdw_old: got %h want 2211", mem_instr); end
        cyc();
        n_cmp++;
        if (mem_instr !== 16'h6655) begin n_bad++; $display("FAIL rdw_new: got %h want 6655", mem_instr); end
        do_done();
    endtask

    task automatic test_wrap();
        logic [15:0] d;
        do_start(14'd16382);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        n_cmp++;
        if (load_wrap !== 1'b1) begin n_bad++; $display("FAIL wrap_set: got %b want 1", load_wrap); end
        n_cmp++;
        if (load_count !== 15'd4) begin n_bad++; $display("FAIL wrap_count: got %0d want 4", load_count); end
        do_done();
        n_cmp++;
        if (load_wrap !== 1'b1) begin n_bad++; $display("FAIL wrap_sticky: got %b want 1", load_wrap); end
        read_word(13'd8191, d);
        n_cmp++;
        if (d !== 16'h0201) begin n_bad++; $display("FAIL wrap_w8191: got %h want 0201", d); end
        read_word(13'd0, d);
        n_cmp++;
        if (d !== 16'h0403) begin n_bad++; $display("FAIL wrap_w0: got %h want 0403", d); end
        do_start(14'd100);
        n_cmp++;
        if ({load_wrap, load_count} !== 16'h0000) begin n_bad++; $display("FAIL wrap_clear: got wrap=%b count=%0d want 0/0", load_wrap, load_count); end
        do_done();
    endtask

    task automatic test_reset_mid_load();
        logic [15:0] d;
        do_start(14'd0);
        send_byte(8'h99);
        n_cmp++;
        if (loading !== 1'b1) begin n_bad++; $display("FAIL midrst_loading_pre: got %b want 1", loading); end
        rst_async = 1'b1;
        #1;
        n_cmp++;
        if ({loading, load_ready, load_wrap} !== 3'b000) begin n_bad++; $display("FAIL midrst_flags: got %b want 000", {loading, load_ready, load_wrap}); end
        n_cmp++;
        if (load_count !== 15'd0) begin n_bad++; $display("FAIL midrst_count: got %0d want 0", load_count); end
        n_cmp++;
        if (mem_instr !== 16'h0000) begin n_bad++; $display("FAIL midrst_instr: got %h want 0000", mem_instr); end
        load_start = 1'b1;
        load_base  = 14'd0;
        cyc();
        cyc();
        n_cmp++;
        if ({loading, load_ready} !== 2'b00) begin n_bad++; $display("FAIL midrst_start_ignored: got %b want 00", {loading, load_ready}); end
        load_start = 1'b0;
        rst_async  = 1'b0;
        cyc();
        n_cmp++;
        if (loading !== 1'b0) begin n_bad++; $display("FAIL midrst_after_release: got %b want 0", loading); end
        read_word(13'd0, d);
        n_cmp++;
        if (d !== 16'h0403) begin n_bad++; $display("FAIL midrst_w0: got %h want 0403", d); end
    endtask

    initial begin
        rst_async     = 1'b1;
        mem_inst_addr = 13'd0;
        load_start    = 1'b0;
        load_base     = 14'd0;
        load_byte     = 8'd0;
        load_valid    = 1'b0;
        load_done     = 1'b0;
        test_reset();
        test_aligned();
        test_odd_base();
        test_flush();
        test_read_during_write();
        test_wrap();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
